// File: rtl/arm_writeback.sv
// ---------------------------------------------------------------------------
// arm_writeback -- writeback stage of the ARM integer pipeline.
//
// Takes one retiring instruction per clock from the memory stage. It formats
// load data (unaligned word rotate, byte/halfword extract, sign/zero extend)
// and drives two register-file write ports: Rd on port 0, and the
// auto-indexed base Rn on port 1. The stage also holds the CPSR NZCV flags
// and raises a one-cycle PC redirect whenever R15 is written.
//
// Every output is registered, so a write strobe appears one cycle after the
// accept (accept = in_valid && in_ready).
//
// Optional build macro: WB_RETIRE_CNT_EN
//   When defined, the stage gains a 32-bit retire_count output. The counter
//   increments on every accept and wraps.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   memory-stage handshake (in_ready = !rf_busy)
//   rf_busy               register file cannot take a write this cycle
//   alu_result            execute result / address
//   mem_rdata             raw aligned word from data memory
//   mem_addr_lo           low two address bits of the load
//   is_load, ld_size,     load formatting controls
//   ld_signed
//   rd, rd_we             destination register and its write enable
//   rn, rn_we, rn_value   base register writeback
//   flags_in, flags_we    NZCV from execute and its update enable
//   rf_we0/waddr0/wdata0  write port 0 (Rd)
//   rf_we1/waddr1/wdata1  write port 1 (Rn)
//   cpsr_flags            current NZCV
//   pc_redirect           one-cycle pulse when R15 is written
//   pc_target             redirect address (word aligned)
//   retire_count          (WB_RETIRE_CNT_EN only) retired instruction count
// ---------------------------------------------------------------------------
module arm_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rf_busy,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_addr_lo,
  input  logic              is_load,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [REG_AW-1:0] rd,
  input  logic              rd_we,
  input  logic [REG_AW-1:0] rn,
  input  logic              rn_we,
  input  logic [DATA_W-1:0] rn_value,
  input  logic [3:0]        flags_in,
  input  logic              flags_we,
  output logic              rf_we0,
  output logic [REG_AW-1:0] rf_waddr0,
  output logic [DATA_W-1:0] rf_wdata0,
  output logic              rf_we1,
  output logic [REG_AW-1:0] rf_waddr1,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic [3:0]        cpsr_flags,
  output logic              pc_redirect,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]       retire_count,
`endif
  output logic [DATA_W-1:0] pc_target
);

  logic              w_accept;
  logic              w_rd_is_pc;
  logic              w_rn_is_pc;
  logic              w_port1_ok;
  logic [DATA_W-1:0] w_rot_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_rd_data;

  logic              r_we0;
  logic [REG_AW-1:0] r_waddr0;
  logic [DATA_W-1:0] r_wdata0;
  logic              r_we1;
  logic [REG_AW-1:0] r_waddr1;
  logic [DATA_W-1:0] r_wdata1;
  logic [3:0]        r_flags;
  logic              r_redirect;
  logic [DATA_W-1:0] r_target;

  assign in_ready = !rf_busy;
  assign w_accept = in_valid && !rf_busy;

  // R15 is the all-ones register index.
  assign w_rd_is_pc = &rd;
  assign w_rn_is_pc = &rn;

  // Port 1 gives way to port 0 when both target the same register, so the
  // loaded value wins. A base writeback to R15 is dropped and does not
  // redirect.
  assign w_port1_ok = rn_we && !(rd_we && (rd == rn)) && !w_rn_is_pc;

  // Load data formatting
  always_comb begin
    w_rot_word = mem_rdata;
    w_byte     = mem_rdata[7:0];
    case (mem_addr_lo)
      2'd0: begin
        w_rot_word = mem_rdata;
        w_byte     = mem_rdata[7:0];
      end
      2'd1: begin
        w_rot_word = {mem_rdata[7:0], mem_rdata[31:8]};
        w_byte     = mem_rdata[15:8];
      end
      2'd2: begin
        w_rot_word = {mem_rdata[15:0], mem_rdata[31:16]};
        w_byte     = mem_rdata[23:16];
      end
      default: begin
        w_rot_word = {mem_rdata[23:0], mem_rdata[31:24]};
        w_byte     = mem_rdata[31:24];
      end
    endcase
  end

  // Halfword selection uses only addr[1]; an odd halfword address is not
  // realigned.
  assign w_half = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load_data = w_rot_word;
    case (ld_size)
      2'b01:   w_load_data = {{24{ld_signed & w_byte[7]}}, w_byte};
      2'b10:   w_load_data = {{16{ld_signed & w_half[15]}}, w_half};
      default: w_load_data = w_rot_word;   // 00 and 11 are word loads
    endcase
  end

  assign w_rd_data = is_load ? w_load_data : alu_result;

  // Output registers. The strobes are recomputed every cycle, so they fall
  // after one cycle. Address and data registers hold their last accepted
  // value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we0      <= 1'b0;
      r_waddr0   <= '0;
      r_wdata0   <= '0;
      r_we1      <= 1'b0;
      r_waddr1   <= '0;
      r_wdata1   <= '0;
      r_flags    <= 4'b0000;
      r_redirect <= 1'b0;
      r_target   <= '0;
    end else begin
      r_we0      <= w_accept && rd_we;
      r_we1      <= w_accept && w_port1_ok;
      r_redirect <= w_accept && rd_we && w_rd_is_pc;
      if (w_accept) begin
        r_waddr0 <= rd;
        r_wdata0 <= w_rd_data;
        r_waddr1 <= rn;
        r_wdata1 <= rn_value;
        if (flags_we) begin
          r_flags <= flags_in;
        end
        if (rd_we && w_rd_is_pc) begin
          r_target <= {w_rd_data[DATA_W-1:2], 2'b00};
        end
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_accept) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;   // wraps naturally
    end
  end

  assign retire_count = r_retire_cnt;
`endif

  assign rf_we0      = r_we0;
  assign rf_waddr0   = r_waddr0;
  assign rf_wdata0   = r_wdata0;
  assign rf_we1      = r_we1;
  assign rf_waddr1   = r_waddr1;
  assign rf_wdata1   = r_wdata1;
  assign cpsr_flags  = r_flags;
  assign pc_redirect = r_redirect;
  assign pc_target   = r_target;

endmodule

// File: tb/tb_arm_writeback.sv
// ---------------------------------------------------------------------------
// tb_arm_writeback -- self-checking bench for arm_writeback.
// Table-driven vectors are applied back to back, with expectations queued on
// a scoreboard at drive time and popped when the outputs are sampled.
// Hand-written sequences cover the pulse width, the stall, and reset applied
// mid-stream.
// ---------------------------------------------------------------------------
module tb_arm_writeback;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        rf_busy;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_addr_lo;
  logic        is_load;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [3:0]  rd;
  logic        rd_we;
  logic [3:0]  rn;
  logic        rn_we;
  logic [31:0] rn_value;
  logic [3:0]  flags_in;
  logic        flags_we;
  logic        rf_we0;
  logic [3:0]  rf_waddr0;
  logic [31:0] rf_wdata0;
  logic        rf_we1;
  logic [3:0]  rf_waddr1;
  logic [31:0] rf_wdata1;
  logic [3:0]  cpsr_flags;
  logic        pc_redirect;
  logic [31:0] pc_target;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
  logic [31:0] exp_cnt;
`endif

  int total;
  int bad;

  arm_writeback #(.DATA_W(32), .REG_AW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rf_busy     (rf_busy),
    .alu_result  (alu_result),
    .mem_rdata   (mem_rdata),
    .mem_addr_lo (mem_addr_lo),
    .is_load     (is_load),
    .ld_size     (ld_size),
    .ld_signed   (ld_signed),
    .rd          (rd),
    .rd_we       (rd_we),
    .rn          (rn),
    .rn_we       (rn_we),
    .rn_value    (rn_value),
    .flags_in    (flags_in),
    .flags_we    (flags_we),
    .rf_we0      (rf_we0),
    .rf_waddr0   (rf_waddr0),
    .rf_wdata0   (rf_wdata0),
    .rf_we1      (rf_we1),
    .rf_waddr1   (rf_waddr1),
    .rf_wdata1   (rf_wdata1),
    .cpsr_flags  (cpsr_flags),
    .pc_redirect (pc_redirect),
`ifdef WB_RETIRE_CNT_EN
    .retire_count(retire_count),
`endif
    .pc_target   (pc_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [1:0]  lo;
    logic        ld;
    logic [1:0]  size;
    logic        sgn;
    logic [3:0]  rd;
    logic        rd_we;
    logic [3:0]  rn;
    logic        rn_we;
    logic [31:0] rn_val;
    logic [3:0]  flags;
    logic        flags_we;
    // expected outputs one cycle later
    logic        e_we0;
    logic [31:0] e_d0;
    logic        e_we1;
    logic        e_redir;
    logic [31:0] e_target;
    logic [3:0]  e_cpsr;
  } vec_t;

  typedef struct {
    string       name;
    logic        we0;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic        we1;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic        redir;
    logic [31:0] target;
    logic [3:0]  cpsr;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    rf_busy     = 1'b0;
    alu_result  = '0;
    mem_rdata   = '0;
    mem_addr_lo = '0;
    is_load     = 1'b0;
    ld_size     = '0;
    ld_signed   = 1'b0;
    rd          = '0;
    rd_we       = 1'b0;
    rn          = '0;
    rn_we       = 1'b0;
    rn_value    = '0;
    flags_in    = '0;
    flags_we    = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    in_valid    = 1'b1;
    alu_result  = v.alu;
    mem_rdata   = v.mem;
    mem_addr_lo = v.lo;
    is_load     = v.ld;
    ld_size     = v.size;
    ld_signed   = v.sgn;
    rd          = v.rd;
    rd_we       = v.rd_we;
    rn          = v.rn;
    rn_we       = v.rn_we;
    rn_value    = v.rn_val;
    flags_in    = v.flags;
    flags_we    = v.flags_we;
  endtask

  // Pops one expectation and compares it with the sampled outputs.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty got=0 want=1");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".we0"}, {31'd0, rf_we0}, {31'd0, e.we0});
    if (e.we0) begin
      chk({e.name, ".waddr0"}, {28'd0, rf_waddr0}, {28'd0, e.a0});
      chk({e.name, ".wdata0"}, rf_wdata0, e.d0);
    end
    chk({e.name, ".we1"}, {31'd0, rf_we1}, {31'd0, e.we1});
    if (e.we1) begin
      chk({e.name, ".waddr1"}, {28'd0, rf_waddr1}, {28'd0, e.a1});
      chk({e.name, ".wdata1"}, rf_wdata1, e.d1);
    end
    chk({e.name, ".redirect"}, {31'd0, pc_redirect}, {31'd0, e.redir});
    if (e.redir) chk({e.name, ".target"}, pc_target, e.target);
    chk({e.name, ".cpsr"}, {28'd0, cpsr_flags}, {28'd0, e.cpsr});
    $display("txn %-10s we0=%b a0=%0d d0=%h we1=%b a1=%0d d1=%h redir=%b tgt=%h cpsr=%b",
             e.name, rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1,
             pc_redirect, pc_target, cpsr_flags);
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] alu, input logic [1:0] lo,
                              input logic ld, input logic [1:0] size, input logic sgn,
                              input logic [3:0] rdv, input logic rdwe, input logic [3:0] rnv,
                              input logic rnwe, input logic [31:0] rnval, input logic [3:0] fl,
                              input logic flwe, input logic ewe0, input logic [31:0] ed0,
                              input logic ewe1, input logic eredir, input logic [31:0] etgt,
                              input logic [3:0] ecpsr);
    vec_t v;
    v.name = name; v.alu = alu; v.mem = 32'h80FF7F01; v.lo = lo; v.ld = ld;
    v.size = size; v.sgn = sgn; v.rd = rdv; v.rd_we = rdwe; v.rn = rnv;
    v.rn_we = rnwe; v.rn_val = rnval; v.flags = fl; v.flags_we = flwe;
    v.e_we0 = ewe0; v.e_d0 = ed0; v.e_we1 = ewe1; v.e_redir = eredir;
    v.e_target = etgt; v.e_cpsr = ecpsr;
    return v;
  endfunction

  task automatic push_exp(input string name, input logic we0, input logic [3:0] a0,
                          input logic [31:0] d0, input logic we1, input logic [3:0] a1,
                          input logic [31:0] d1, input logic redir, input logic [31:0] tgt,
                          input logic [3:0] cpsr);
    exp_t e;
    e.name = name; e.we0 = we0; e.a0 = a0; e.d0 = d0; e.we1 = we1; e.a1 = a1;
    e.d1 = d1; e.redir = redir; e.target = tgt; e.cpsr = cpsr;
    sb.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef WB_RETIRE_CNT_EN
    exp_cnt = 0;
`endif
    //            name        alu           lo ld size sg rd   we rn   we rn_val       fl    fwe we0 d0            we1 rdr tgt           cpsr
    vecs[0]  = mk("alu",      32'h12345678, 0, 0, 2'b00, 0, 3,  1, 0,  0, 32'h0,       4'h0, 0,  1, 32'h12345678, 0, 0, 32'h0,       4'h0);
    vecs[1]  = mk("ldrsb_a2", 32'h0,        2, 1, 2'b01, 1, 4,  1, 0,  0, 32'h0,       4'h0, 0,  1, 32'hFFFFFFFF, 0, 0, 32'h0,       4'h0);
    vecs[2]  = mk("ldrh_a2",  32'h0,        2, 1, 2'b10, 0, 5,  1, 0,  0, 32'h0,       4'h0, 0,  1, 32'h000080FF, 0, 0, 32'h0,       4'h0);
    vecs[3]  = mk("ldr_a1",   32'h0,        1, 1, 2'b00, 0, 6,  1, 0,  0, 32'h0,       4'h0, 0,  1, 32'h0180FF7F, 0, 0, 32'h0,       4'h0);
    vecs[4]  = mk("ldrb_a0",  32'h0,        0, 1, 2'b01, 0, 7,  1, 0,  0, 32'h0,       4'h0, 0,  1, 32'h00000001, 0, 0, 32'h0,       4'h0);
    vecs[5]  = mk("ldrsb_a1", 32'h0,        1, 1, 2'b01, 1, 8,  1, 0,  0, 32'h0,       4'h0, 0,  1, 32'h0000007F, 0, 0, 32'h0,       4'h0);
    vecs[6]  = mk("ldrsb_a3", 32'h0,        3, 1, 2'b01, 1, 9,  1, 0,  0, 32'h0,       4'h0, 0,  1, 32'hFFFFFF80, 0, 0, 32'h0,       4'h0);
    vecs[7]  = mk("ldrsh_a0", 32'h0,        0, 1, 2'b10, 1, 10, 1, 0,  0, 32'h0,       4'h0, 0,  1, 32'h00007F01, 0, 0, 32'h0,       4'h0);
    vecs[8]  = mk("ldrsh_a3", 32'h0,        3, 1, 2'b10, 1, 11, 1, 0,  0, 32'h0,       4'h0, 0,  1, 32'hFFFF80FF, 0, 0, 32'h0,       4'h0);
    vecs[9]  = mk("ld11_a2",  32'h0,        2, 1, 2'b11, 0, 12, 1, 0,  0, 32'h0,       4'h0, 0,  1, 32'h7F0180FF, 0, 0, 32'h0,       4'h0);
    vecs[10] = mk("base_wb",  32'h0,        0, 1, 2'b00, 0, 2,  1, 5,  1, 32'h1004,    4'h0, 0,  1, 32'h80FF7F01, 1, 0, 32'h0,       4'h0);
    vecs[11] = mk("base_conf",32'h0,        0, 1, 2'b00, 0, 2,  1, 2,  1, 32'h1004,    4'h0, 0,  1, 32'h80FF7F01, 0, 0, 32'h0,       4'h0);
    vecs[12] = mk("rn_pc",    32'h55,       0, 0, 2'b00, 0, 1,  1, 15, 1, 32'h2000,    4'h0, 0,  1, 32'h00000055, 0, 0, 32'h0,       4'h0);
    vecs[13] = mk("flags",    32'h0,        0, 0, 2'b00, 0, 0,  0, 0,  0, 32'h0,       4'hA, 1,  0, 32'h0,        0, 0, 32'h0,       4'hA);

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.we0",    {31'd0, rf_we0},      32'd0);
    chk("reset.we1",    {31'd0, rf_we1},      32'd0);
    chk("reset.redir",  {31'd0, pc_redirect}, 32'd0);
    chk("reset.wdata0", rf_wdata0,            32'd0);
    chk("reset.cpsr",   {28'd0, cpsr_flags},  32'd0);
    chk("reset.ready",  {31'd0, in_ready},    32'd1);

    // Table vectors are driven back to back, one accept per clock.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      push_exp(vecs[i].name, vecs[i].e_we0, vecs[i].rd, vecs[i].e_d0, vecs[i].e_we1,
               vecs[i].rn, vecs[i].rn_val, vecs[i].e_redir, vecs[i].e_target, vecs[i].e_cpsr);
`ifdef WB_RETIRE_CNT_EN
      exp_cnt++;
`endif
      @(posedge clk);
      #1;
      check_out();
    end

    // Flags hold when flags_we is low.
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1;
    flags_in = 4'h5;
    push_exp("flags_hold", 0, 0, 0, 0, 0, 0, 0, 0, 4'hA);
`ifdef WB_RETIRE_CNT_EN
    exp_cnt++;
`endif
    @(posedge clk);
    #1;
    check_out();

    // PC write: redirect must last exactly one cycle.
    @(negedge clk);
    idle_inputs();
    in_valid   = 1'b1;
    alu_result = 32'h00000103;
    rd         = 4'd15;
    rd_we      = 1'b1;
    push_exp("pc_write", 1, 4'd15, 32'h00000103, 0, 0, 0, 1, 32'h00000100, 4'hA);
`ifdef WB_RETIRE_CNT_EN
    exp_cnt++;
`endif
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
    idle_inputs();
    push_exp("pc_after", 0, 0, 0, 0, 0, 0, 0, 0, 4'hA);
    @(posedge clk);
    #1;
    check_out();

    // Stall: rf_busy blocks the accept, strobes, and flag update.
    @(negedge clk);
    idle_inputs();
    rf_busy    = 1'b1;
    in_valid   = 1'b1;
    rd         = 4'd4;
    rd_we      = 1'b1;
    rn         = 4'd6;
    rn_we      = 1'b1;
    rd         = 4'd15;
    flags_in   = 4'h1;
    flags_we   = 1'b1;
    #1;
    chk("stall.ready", {31'd0, in_ready}, 32'd0);
    push_exp("stall", 0, 0, 0, 0, 0, 0, 0, 0, 4'hA);
    @(posedge clk);
    #1;
    check_out();

`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", retire_count, exp_cnt);
`endif

    // Reset mid-stream drops a pending write pulse immediately.
    @(negedge clk);
    idle_inputs();
    in_valid   = 1'b1;
    alu_result = 32'h0000DEAD;
    rd         = 4'd7;
    rd_we      = 1'b1;
    flags_in   = 4'hF;
    flags_we   = 1'b1;
    push_exp("pre_reset", 1, 4'd7, 32'h0000DEAD, 0, 0, 0, 0, 0, 4'hF);
    @(posedge clk);
    #1;
    check_out();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.we0",    {31'd0, rf_we0},     32'd0);
    chk("midrst.wdata0", rf_wdata0,           32'd0);
    chk("midrst.waddr0", {28'd0, rf_waddr0},  32'd0);
    chk("midrst.cpsr",   {28'd0, cpsr_flags}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("midrst.count",  retire_count,        32'd0);
`endif
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    push_exp("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    @(posedge clk);
    #1;
    check_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_writeback.md
Name: arm_writeback

Overview:
Final (writeback) stage of the ARM integer pipeline. Accepts one retiring instruction per clock from the memory stage and formats load data (word rotate, byte/halfword extract, sign/zero extend). Drives two register-file write ports: destination Rd, and base Rn for auto-indexed loads/stores. Also owns the CPSR NZCV flags and raises a PC redirect when R15 is written.

Parameters:
DATA_W, 32, datapath width (only 32 supported)
REG_AW, 4, register index width (R0–R15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  memory-stage result valid
in_ready  out  1  stage can accept; equals !rf_busy (combinational)
rf_busy  in  1  register file cannot take a write this cycle
alu_result  in  32  execute result / address
mem_rdata  in  32  raw aligned word from data memory
mem_addr_lo  in  2  low address bits of the load
is_load  in  1  Rd data comes from memory
ld_size  in  2  00 word, 01 byte, 10 halfword, 11 treated as word
ld_signed  in  1  sign-extend byte/halfword
rd  in  4  destination register
rd_we  in  1  write Rd
rn  in  4  base register
rn_we  in  1  base writeback
rn_value  in  32  updated base value
flags_in  in  4  NZCV from execute
flags_we  in  1  update CPSR flags
rf_we0  out  1  port 0 write strobe (Rd)
rf_waddr0  out  4  port 0 address
rf_wdata0  out  32  port 0 data
rf_we1  out  1  port 1 write strobe (Rn)
rf_waddr1  out  4  port 1 address
rf_wdata1  out  32  port 1 data
cpsr_flags  out  4  current NZCV
pc_redirect  out  1  one-cycle pulse: R15 written
pc_target  out  32  redirect address

Behaviour:
- Accept = in_valid && in_ready. All outputs are registered, so latency is 1 cycle from accept to write strobe.
- rf_we0, rf_we1 and pc_redirect are single-cycle pulses. They are 0 in any cycle following a non-accept.
- Load formatting (is_load=1), where a = mem_addr_lo:
  - Word: mem_rdata rotated right by 8*a (ARMv4 unaligned LDR).
  - Byte: byte a of mem_rdata, zero- or sign-extended.
  - Halfword: bits selected by a[1] (a[0] ignored), zero- or sign-extended.
- If is_load=0, Rd data = alu_result.
- Port 0 (Rd): rf_we0 = rd_we, rf_waddr0 = rd, rf_wdata0 = formatted data.
- Port 1 (Rn): rf_we1 = rn_we, rf_waddr1 = rn, rf_wdata1 = rn_value.
- Conflicts on port 1:
  - rd_we && rn_we && rd==rn: port 1 suppressed; the loaded/Rd value wins.
  - rn==15 with rn_we: port 1 suppressed, no redirect.
- rd==15 with rd_we:
  - rf_we0 still asserted.
  - pc_redirect pulses in the same cycle.
  - pc_target = data with bits[1:0] cleared.
- cpsr_flags loads flags_in on accept when flags_we=1, otherwise holds.
- Reset (async, rst_n low): every output register cleared to 0, including cpsr_flags=0000. Reset mid-operation drops any pending write pulse.
- rf_busy high: in_ready=0, nothing accepted, no strobes; cpsr_flags holds.

Optional Feature:
WB_RETIRE_CNT_EN
- Defined: adds output retire_count, 32 bits.
- retire_count increments on every accept and wraps at 2^32−1 → 0.
- retire_count is cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream → all outputs 0 immediately; after release, cpsr_flags=0.
- ALU write: alu_result=0x12345678, rd=3, rd_we=1, is_load=0 → next cycle rf_we0=1, waddr0=3, wdata0=0x12345678, rf_we1=0.
- Loads, with mem_rdata=0x80FF7F01:
  - Byte, a=2, signed → 0xFFFFFFFF.
  - Halfword, a=2, unsigned → 0x000080FF.
  - Word, a=1 → 0x0180FF7F.
- Base writeback: LDR with rd=2, rn=5, rn_we=1, rn_value=0x1004 → both ports write in the same cycle.
- Base writeback conflict: rn=2 (same as rd) → only port 0 writes.
- PC write: rd=15, data=0x00000103 → pc_redirect=1 for exactly one cycle, pc_target=0x00000100, rf_we0=1.
- Flags and stall:
  - flags_we=1, flags_in=1010 → cpsr_flags=1010 next cycle.
  - rf_busy=1 with in_valid=1 → in_ready=0, no strobes, flags unchanged.
